alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Sequencing controller in front of the combinational 64-bit ALU.
- Accepts one operation at a time over a valid/ready request channel.
- Single-cycle modes (ADD, SUB, AND, OR, XOR, NOT): instantiates the ALU and registers its S/S2/PSW.
- MUL and DIV, which the ALU leaves unimplemented: runs multi-cycle unsigned shift-add multiply and restoring divide.
- Returns every result over a valid/ready response channel. Sits between decode/issue and writeback.

Parameters:
XLEN, 64, operand width; must equal the ALU width, and only 64 is supported.
PSW_W, 16, status word width; matches the ALU PSW port.
CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_mode  input  4  operation code, MODE_* from para.v
req_a  input  XLEN  operand A
req_b  input  XLEN  operand B
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_s  output  XLEN  primary result (sum, difference, logic result, product low half, quotient)
rsp_s2  output  XLEN  secondary result (product high half, remainder, otherwise 0)
rsp_psw  output  PSW_W  flags at CF_BIT, OF_BIT, ZF_BIT (para.v); all other bits 0
busy  output  1  high in every state except IDLE

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_s=0, rsp_s2=0, rsp_psw=0, busy=0, counter=0.
- States: IDLE, MUL, DIV, DONE.
- req_ready = (state==IDLE). A request is accepted on the edge where req_valid && req_ready. Operands and mode are latched on that edge.
- IDLE, accepting a single-cycle mode: drive the latched/incoming operands into the ALU and register its S, S2, PSW. Go to DONE. rsp_valid is high the cycle after acceptance (latency 1).
- IDLE, accepting MUL: acc_hi=0, acc_lo=B, cnt=0. Go to MUL.
  - Each MUL cycle: if acc_lo[0], add A into acc_hi with a 65-bit add keeping the carry. Shift {carry,acc_hi,acc_lo} right by 1. cnt++.
  - After XLEN iterations (cnt==XLEN-1 on that step): rsp_s=acc_lo (low 64 bits), rsp_s2=acc_hi (high 64 bits). CF=1 iff high half is nonzero. ZF=1 iff the full 128-bit product is 0. Go to DONE. Latency XLEN+1 = 65 cycles.
- IDLE, accepting DIV with B!=0: rem=0, quo=A, cnt=0. Go to DIV.
  - Each DIV cycle: shift {rem,quo} left by 1 and compute rem-B. If there is no borrow, rem takes the difference and quo[0]=1. cnt++.
  - After XLEN iterations: rsp_s=quo, rsp_s2=rem. ZF=1 iff quo==0. Go to DONE. Latency 65.
- DIV with B==0: no iteration. rsp_s=all ones, rsp_s2=A, OF=1, ZF=0. Go to DONE. Latency 1.
- Undefined mode code: rsp_s=0, rsp_s2=0, rsp_psw has only ZF set. Latency 1.
- DONE: rsp_valid=1, and outputs hold stable until rsp_ready. On the rsp_valid && rsp_ready edge: go to IDLE, rsp_valid=0. No new request is accepted in the same cycle; the minimum issue interval is 2 cycles.
- req_valid during MUL/DIV/DONE is ignored (req_ready=0). The requester holds its request.
- rsp_ready while not in DONE has no effect.
- rst_n asserted mid-MUL/DIV/DONE: the operation is aborted immediately, all outputs return to reset values, and no response is produced.
- All arithmetic is unsigned. Iteration adds carry out of bit 63 into the 65th bit; nothing is truncated before the final result.

Decomposition:
- MODE_* codes, CF_BIT/OF_BIT/ZF_BIT, and the state encoding belong in the shared para.v include.
- One sub-module is natural: mul_div_iter (iterative shift-add / restoring-divide datapath with counter and done strobe).
- The ALU is instantiated unchanged for single-cycle modes.

Test Plan:
1. ADD A=0xFFFFFFFFFFFFFFFF, B=1 -> rsp_valid 1 cycle after accept; S=0, S2=0, CF=1, ZF=1.
2. MUL A=0xFFFFFFFFFFFFFFFF, B=2 -> rsp_valid 65 cycles after accept; S=0xFFFFFFFFFFFFFFFE, S2=1, CF=1, ZF=0.
3. DIV A=100, B=7 -> S=14, S2=2, ZF=0, latency 65. DIV A=5, B=0 -> S=all ones, S2=5, OF=1, latency 1.
4. Backpressure: hold rsp_ready=0 for 10 cycles after SUB A=3, B=5 -> rsp_valid and S=0xFFFFFFFFFFFFFFFE stable throughout; req_ready=0 until the handshake, then 1 the next cycle.
5. Reset mid-operation: deassert rst_n 20 cycles into MUL -> rsp_valid=0 and busy=0 immediately; a subsequent AND A=0xF0, B=0x3C returns S=0x30.
6. Back-to-back: XOR then NOT with req_valid held high and rsp_ready=1 -> two responses 2 cycles apart; NOT A=0 gives S=all ones, ZF=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: widths, mode codes, flag positions, states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam int XLEN  = 64;
  localparam int PSW_W = 16;
  localparam int CNT_W = 7;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_OR  = 4'd3;
  localparam logic [3:0] MODE_XOR = 4'd4;
  localparam logic [3:0] MODE_NOT = 4'd5;
  localparam logic [3:0] MODE_MUL = 4'd6;
  localparam logic [3:0] MODE_DIV = 4'd7;

  localparam int CF_BIT = 0;
  localparam int OF_BIT = 1;
  localparam int ZF_BIT = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  // Build a status word with only the three defined flags populated.
  function automatic logic [PSW_W-1:0] mk_psw(input logic cf, input logic of, input logic zf);
    logic [PSW_W-1:0] p;
    p         = '0;
    p[CF_BIT] = cf;
    p[OF_BIT] = of;
    p[ZF_BIT] = zf;
    return p;
  endfunction

endpackage

// File: rtl/alu64.sv
// Single-cycle arithmetic/logic datapath for ADD, SUB, AND, OR, XOR and NOT; MUL/DIV codes return zero.
// Latency: 0 (purely combinational).
// Backpressure: none.
module alu64
  import alu_seq_pkg::*;
(
  input  logic [3:0]       mode,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  s,
  output logic [XLEN-1:0]  s2,
  output logic [PSW_W-1:0] psw
);

  logic [XLEN:0] wide;
  logic          cf;
  logic          of;

  // Result and carry/overflow per mode; unsupported modes yield zero.
  always_comb begin
    s    = '0;
    cf   = 1'b0;
    of   = 1'b0;
    wide = '0;
    case (mode)
      MODE_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        s    = wide[XLEN-1:0];
        cf   = wide[XLEN];
        of   = (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      end
      MODE_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        s    = wide[XLEN-1:0];
        cf   = wide[XLEN];
        of   = (a[XLEN-1] != b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      end
      MODE_AND: s = a & b;
      MODE_OR:  s = a | b;
      MODE_XOR: s = a ^ b;
      MODE_NOT: s = ~a;
      default:  s = '0;
    endcase
  end

  assign s2  = '0;
  assign psw = mk_psw(cf, of, s == '0);

endmodule

// File: rtl/alu_seq_mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: XLEN cycles after start; done and final hi/lo are presented combinationally on the last step.
// Backpressure: none; the caller must not restart while an operation is running.
module alu_seq_mul_div_iter
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            start_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  logic             active;
  logic             is_div;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  opnd;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  hi_nxt;
  logic [XLEN-1:0]  lo_nxt;
  logic [XLEN:0]    sum;
  logic [XLEN:0]    rem_sh;

  // One iteration: multiply keeps the 65th carry bit through the shift; divide restores on borrow.
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd} : '0);
    rem_sh = {hi_q, lo_q[XLEN-1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd}) begin
        hi_nxt = XLEN'(rem_sh - {1'b0, opnd});
        lo_nxt = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign done = active && (cnt == CNT_W'(XLEN - 1));
  assign lo   = lo_nxt;
  assign hi   = hi_nxt;

  // Accumulator and counter; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      active <= 1'b1;
      is_div <= start_div;
      cnt    <= '0;
      opnd   <= start_div ? b : a;
      hi_q   <= '0;
      lo_q   <= start_div ? a : b;
    end else if (active) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
      cnt  <= done ? '0 : cnt + CNT_W'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencing controller: single-cycle ops via the ALU, MUL/DIV via the iterative datapath.
// Latency: 1 cycle for ALU ops, divide-by-zero and undefined modes; 65 cycles for MUL/DIV.
// Backpressure: one op in flight; req_ready only in IDLE; result held until rsp_ready.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_mode,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_s,
  output logic [XLEN-1:0]  rsp_s2,
  output logic [PSW_W-1:0] rsp_psw,
  output logic             busy
);

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            b_zero;
  logic            iter_start;
  logic            iter_done;
  logic [XLEN-1:0] iter_lo;
  logic [XLEN-1:0] iter_hi;
  logic [XLEN-1:0] alu_s;
  logic [XLEN-1:0] alu_s2;
  logic [PSW_W-1:0] alu_psw;

  assign accept     = req_valid && (state == ST_IDLE);
  assign b_zero     = (req_b == '0);
  assign iter_start = accept && ((req_mode == MODE_MUL) || ((req_mode == MODE_DIV) && !b_zero));

  alu64 u_alu (
    .mode (req_mode),
    .a    (req_a),
    .b    (req_b),
    .s    (alu_s),
    .s2   (alu_s2),
    .psw  (alu_psw)
  );

  alu_seq_mul_div_iter u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (iter_start),
    .start_div (req_mode == MODE_DIV),
    .a         (req_a),
    .b         (req_b),
    .done      (iter_done),
    .lo        (iter_lo),
    .hi        (iter_hi)
  );

  // Next state and handshake outputs derived from the current state.
  always_comb begin
    state_nxt = state;
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_mode == MODE_MUL)                  state_nxt = ST_MUL;
          else if ((req_mode == MODE_DIV) && !b_zero) state_nxt = ST_DIV;
          else                                        state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (iter_done) state_nxt = ST_DONE;
      ST_DONE:        if (rsp_ready) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // State register and result capture; results only change on accept or iteration completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rsp_s   <= '0;
      rsp_s2  <= '0;
      rsp_psw <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        case (req_mode)
          MODE_ADD, MODE_SUB, MODE_AND, MODE_OR, MODE_XOR, MODE_NOT: begin
            rsp_s   <= alu_s;
            rsp_s2  <= alu_s2;
            rsp_psw <= alu_psw;
          end
          MODE_MUL: ;
          MODE_DIV: begin
            if (b_zero) begin
              rsp_s   <= '1;
              rsp_s2  <= req_a;
              rsp_psw <= mk_psw(1'b0, 1'b1, 1'b0);
            end
          end
          default: begin
            rsp_s   <= '0;
            rsp_s2  <= '0;
            rsp_psw <= mk_psw(1'b0, 1'b0, 1'b1);
          end
        endcase
      end else if (iter_done) begin
        rsp_s  <= iter_lo;
        rsp_s2 <= iter_hi;
        if (state == ST_DIV) rsp_psw <= mk_psw(1'b0, 1'b0, iter_lo == '0);
        else                 rsp_psw <= mk_psw(iter_hi != '0, 1'b0, {iter_hi, iter_lo} == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard of expected results, one task per scenario.
// Latency: checks 1-cycle and 65-cycle response timing.
// Backpressure: exercises held responses, reset abort and back-to-back issue.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [63:0] s;
    logic [63:0] s2;
    logic [15:0] psw;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_mode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_s;
  logic [63:0] rsp_s2;
  logic [15:0] rsp_psw;
  logic        busy;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_s2    (rsp_s2),
    .rsp_psw   (rsp_psw),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain arithmetic operators.
  function automatic exp_t model(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b);
    exp_t         e;
    logic [64:0]  w;
    logic [127:0] p;
    logic         cf, of, zf;
    e.s = '0; e.s2 = '0; e.psw = '0; e.lat = 1;
    cf = 1'b0; of = 1'b0; zf = 1'b0;
    case (m)
      MODE_ADD: begin
        w = {1'b0, a} + {1'b0, b}; e.s = w[63:0]; cf = w[64];
        of = (a[63] == b[63]) && (e.s[63] != a[63]); zf = (e.s == 0);
      end
      MODE_SUB: begin
        w = {1'b0, a} - {1'b0, b}; e.s = w[63:0]; cf = w[64];
        of = (a[63] != b[63]) && (e.s[63] != a[63]); zf = (e.s == 0);
      end
      MODE_AND: begin e.s = a & b; zf = (e.s == 0); end
      MODE_OR:  begin e.s = a | b; zf = (e.s == 0); end
      MODE_XOR: begin e.s = a ^ b; zf = (e.s == 0); end
      MODE_NOT: begin e.s = ~a;    zf = (e.s == 0); end
      MODE_MUL: begin
        p = {64'd0, a} * {64'd0, b}; e.s = p[63:0]; e.s2 = p[127:64];
        cf = (e.s2 != 0); zf = (p == 0); e.lat = 65;
      end
      MODE_DIV: begin
        if (b == 0) begin e.s = '1; e.s2 = a; of = 1'b1; end
        else begin e.s = a / b; e.s2 = a % b; zf = (e.s == 0); e.lat = 65; end
      end
      default: zf = 1'b1;
    endcase
    e.psw[CF_BIT] = cf;
    e.psw[OF_BIT] = of;
    e.psw[ZF_BIT] = zf;
    return e;
  endfunction

  // Present a request from a falling edge, push its expectation, return just after the accepting edge.
  task automatic issue(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b);
    bit acc = 0;
    req_mode = m; req_a = a; req_b = b; req_valid = 1'b1;
    sb.push_back(model(m, a, b));
    for (int i = 0; i < 300 && !acc; i++) begin
      if (req_ready) begin @(posedge clk); #1; req_valid = 1'b0; acc = 1; end
      else @(negedge clk);
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout mode=%0d got no req_ready, required req_ready=1", m);
      req_valid = 1'b0;
    end
  endtask

  // Count falling edges until rsp_valid and capture the response (no checking here).
  task automatic wait_rsp(output logic [63:0] s, output logic [63:0] s2, output logic [15:0] psw,
                          output int lat, output bit ok);
    ok = 0; lat = 0; s = '0; s2 = '0; psw = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin ok = 1; s = rsp_s; s2 = rsp_s2; psw = rsp_psw; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if ({rsp_s, rsp_s2} !== 128'd0) begin n_fail++; $display("FAIL reset_s got=%h/%h exp=0/0", rsp_s, rsp_s2); end
    n_cmp++; if (rsp_psw !== 16'd0) begin n_fail++; $display("FAIL reset_psw got=%h exp=0", rsp_psw); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [63:0] s, s2; logic [15:0] p; int lat; bit ok; exp_t e;
    issue(MODE_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL add_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if ({s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL add_result got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [63:0] s, s2; logic [15:0] p; int lat; bit ok; exp_t e;
    issue(MODE_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL mul_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if ({s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL mul_result got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
    issue(MODE_MUL, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3211);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || {s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL mul_wide got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
  endtask

  task automatic test_div();
    logic [63:0] s, s2; logic [15:0] p; int lat; bit ok; exp_t e;
    issue(MODE_DIV, 64'd100, 64'd7);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL div_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if ({s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL div_result got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
    issue(MODE_DIV, 64'd5, 64'd0);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL div0_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if ({s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL div0_result got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
    issue(MODE_DIV, 64'hF000_0000_0000_0003, 64'hF000_0000_0000_0001);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || {s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL div_big got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
  endtask

  task automatic test_undefined();
    logic [63:0] s, s2; logic [15:0] p; int lat; bit ok; exp_t e;
    issue(4'hC, 64'hDEAD, 64'hBEEF);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL undef_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if ({s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL undef_result got=%h/%h/%h exp=%h/%h/%h", s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [63:0] s, s2; logic [15:0] p; int lat; bit ok; exp_t e;
    rsp_ready = 1'b0;
    issue(MODE_SUB, 64'd3, 64'd5);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != 1 || {s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL sub_result lat=%0d got=%h/%h/%h exp lat=1 %h/%h/%h", lat, s, s2, p, e.s, e.s2, e.psw); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_s !== e.s || rsp_psw !== e.psw || req_ready !== 1'b0) begin n_fail++;
        $display("FAIL hold_cycle%0d got v=%b s=%h psw=%h rdy=%b exp v=1 s=%h psw=%h rdy=0",
                 i, rsp_valid, rsp_s, rsp_psw, req_ready, e.s, e.psw); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL release got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] s, s2; logic [15:0] p; int lat; bit ok; exp_t e; int seen = 0;
    issue(MODE_MUL, 64'h0123_4567_89AB_CDEF, 64'h7);
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL mid_mul got busy=%b v=%b exp busy=1 v=0", busy, rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL abort got busy=%b v=%b rdy=%b exp busy=0 v=0 rdy=1", busy, rsp_valid, req_ready); end
    n_cmp++; if ({rsp_s, rsp_s2, rsp_psw} !== '0) begin n_fail++;
      $display("FAIL abort_outputs got=%h/%h/%h exp=0/0/0", rsp_s, rsp_s2, rsp_psw); end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL aborted_rsp got %0d valid cycles exp 0", seen); end
    issue(MODE_AND, 64'hF0, 64'h3C);
    wait_rsp(s, s2, p, lat, ok); e = sb.pop_front();
    n_cmp++; if (!ok || lat != 1 || {s, s2, p} !== {e.s, e.s2, e.psw}) begin n_fail++;
      $display("FAIL and_after_reset lat=%0d got=%h/%h/%h exp lat=1 %h/%h/%h", lat, s, s2, p, e.s, e.s2, e.psw); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t[$]; exp_t e;
    rsp_ready = 1'b1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start got rdy=%b exp 1", req_ready); end
    req_mode = MODE_XOR; req_a = 64'hAAAA_5555_0000_FFFF; req_b = 64'h0F0F_0F0F_0F0F_0F0F; req_valid = 1'b1;
    sb.push_back(model(MODE_XOR, 64'hAAAA_5555_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F));
    @(posedge clk); #1;
    req_mode = MODE_NOT; req_a = 64'd0; req_b = 64'h1234;
    sb.push_back(model(MODE_NOT, 64'd0, 64'h1234));
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        t.push_back(i);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++; if ({rsp_s, rsp_s2, rsp_psw} !== {e.s, e.s2, e.psw}) begin n_fail++;
            $display("FAIL b2b_rsp%0d got=%h/%h/%h exp=%h/%h/%h", t.size(), rsp_s, rsp_s2, rsp_psw, e.s, e.s2, e.psw); end
        end
      end
      if (req_valid && req_ready) begin @(posedge clk); #1; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    n_cmp++; if (t.size() != 2 || t[1] - t[0] != 2) begin n_fail++;
      $display("FAIL b2b_spacing got %0d responses spacing=%0d exp 2 responses spacing=2",
               t.size(), (t.size() == 2) ? t[1] - t[0] : -1); end
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_leftover got %0d pending exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_undefined();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
